// File: rtl/ex_mdu.sv
// ex_mdu: EX-stage multiply/divide unit.
// MULT/MULTU/DIV/DIVU results are computed when the op starts and held as
// pending. They reach architectural HI/LO only after a fixed number of busy
// cycles. MTHI/MTLO write HI/LO immediately. MFHI/MFLO read the committed
// registers combinationally.
module ex_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [3:0]  i_op,
   input  logic [31:0] i_rs,
   input  logic [31:0] i_rt,
   output logic        o_busy,
   output logic [31:0] o_result,
   output logic [31:0] or_hi,
   output logic [31:0] or_lo
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MFHI  = 4'd7,
      OP_MFLO  = 4'd8
   } mdu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } mdu_state_e;

   // Result waiting for its commit edge. A cleared we means a divide by zero,
   // which must leave HI/LO untouched.
   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        we;
   } mdu_pend_t;

   mdu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   mdu_pend_t        pend_q, pend_d;
   logic [31:0]      hi_d, lo_d;

   // ---------------------------------------------------------------------
   // Datapath: evaluated on the live operands and captured only at start.
   // ---------------------------------------------------------------------
   logic        mul_sgn, div_sgn;
   logic [63:0] mul_a, mul_b, mul_p;
   logic [31:0] a_mag, b_mag, q_mag, r_mag, div_q, div_r;
   logic        div_nz;

   assign mul_sgn = (mdu_op_e'(i_op) == OP_MULT);
   assign div_sgn = (mdu_op_e'(i_op) == OP_DIV);

   // Extending to 64 bits and keeping the low half of the product gives the
   // exact result for both signed and unsigned operands.
   assign mul_a = {{32{mul_sgn & i_rs[31]}}, i_rs};
   assign mul_b = {{32{mul_sgn & i_rt[31]}}, i_rt};
   assign mul_p = mul_a * mul_b;

   // Signed divide is done on magnitudes and the signs are fixed up after:
   // the quotient truncates toward zero and the remainder takes the sign of
   // the dividend. |0x80000000| still fits as an unsigned 32-bit value, so
   // 0x80000000 / -1 naturally yields 0x80000000 with a remainder of 0.
   assign div_nz = (i_rt != 32'd0);
   assign a_mag  = (div_sgn && i_rs[31]) ? (32'd0 - i_rs) : i_rs;
   assign b_mag  = (div_sgn && i_rt[31]) ? (32'd0 - i_rt) : i_rt;

   // Guarded divider so a zero divisor never reaches the / and % operators.
   always_comb begin
      q_mag = 32'd0;
      r_mag = 32'd0;
      if (div_nz) begin
         q_mag = a_mag / b_mag;
         r_mag = a_mag % b_mag;
      end
   end

   assign div_q = (div_sgn && (i_rs[31] ^ i_rt[31])) ? (32'd0 - q_mag) : q_mag;
   assign div_r = (div_sgn && i_rs[31]) ? (32'd0 - r_mag) : r_mag;

   // ---------------------------------------------------------------------
   // Control
   // ---------------------------------------------------------------------
   // Next-state logic. New ops are accepted only in IDLE, so a stray start
   // while busy cannot disturb the op in flight. The counter is loaded with N
   // at the start edge, and the op commits on the edge where it reads 1. That
   // keeps o_busy high for exactly N cycles.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      hi_d    = or_hi;
      lo_d    = or_lo;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               case (mdu_op_e'(i_op))
                  OP_MULT, OP_MULTU: begin
                     state_d   = S_MUL;
                     cnt_d     = CNT_W'(MULT_CYCLES);
                     pend_d.hi = mul_p[63:32];
                     pend_d.lo = mul_p[31:0];
                     pend_d.we = 1'b1;
                  end
                  OP_DIV, OP_DIVU: begin
                     state_d   = S_DIV;
                     cnt_d     = CNT_W'(DIV_CYCLES);
                     pend_d.hi = div_r;
                     pend_d.lo = div_q;
                     pend_d.we = div_nz;
                  end
                  OP_MTHI: hi_d = i_rs;
                  OP_MTLO: lo_d = i_rs;
                  default: ;
               endcase
            end
         end
         S_MUL, S_DIV: begin
            if (cnt_q <= CNT_W'(1)) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               if (pend_q.we) begin
                  hi_d = pend_q.hi;
                  lo_d = pend_q.lo;
               end
               pend_d = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pend_d  = '0;
         end
      endcase
   end

   // State, counter, pending result and architectural HI/LO. Reset aborts
   // any op in flight and discards its pending result.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         or_hi   <= 32'd0;
         or_lo   <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         or_hi   <= hi_d;
         or_lo   <= lo_d;
      end
   end

   assign o_busy = (state_q != S_IDLE);

   // The read port always shows committed values. The hazard unit is
   // responsible for holding MFHI/MFLO until o_busy drops.
   always_comb begin
      o_result = 32'd0;
      case (mdu_op_e'(i_op))
         OP_MFHI: o_result = or_hi;
         OP_MFLO: o_result = or_lo;
         default: ;
      endcase
   end

endmodule
